// File: rtl/ip_stats_pkg.sv
// ip_stats_pkg: shared constants and helpers for the statistics counter bank.
package ip_stats_pkg;

    // Counter arithmetic modes
    localparam int STATS_WRAP = 0;
    localparam int STATS_SAT  = 1;

    // Read address width for a given channel count; never narrower than 1 bit
    function automatic int calc_aw(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/ip_stats_cell.sv
// ip_stats_cell: one statistics counter with a sticky overflow flag.
// clr_all outranks clr, and clr keeps a same-cycle increment.
module ip_stats_cell
    import ip_stats_pkg::*;
#(
    parameter int INC_WIDTH   = 8,
    parameter int STATS_WIDTH = 32,
    parameter int SATURATE    = STATS_WRAP
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inc_en,
    input  logic [INC_WIDTH-1:0]   inc_value,
    input  logic                   clr,
    input  logic                   clr_all,
    output logic [STATS_WIDTH-1:0] cnt,
    output logic                   ovf
);

    logic [STATS_WIDTH:0]   inc_ext;
    logic [STATS_WIDTH:0]   sum;
    logic [STATS_WIDTH-1:0] cnt_reg, cnt_next;
    logic                   ovf_reg, ovf_next;

    // Next counter value: one extra bit catches the carry-out that flags overflow
    always_comb begin
        inc_ext = '0;
        if (inc_en) begin
            inc_ext[INC_WIDTH-1:0] = inc_value;
        end
        sum      = {1'b0, cnt_reg} + inc_ext;
        cnt_next = sum[STATS_WIDTH-1:0];
        ovf_next = ovf_reg | sum[STATS_WIDTH];
        if (SATURATE == STATS_SAT && sum[STATS_WIDTH]) begin
            cnt_next = '1;
        end
        // A clearing read restarts from the coincident increment, which cannot overflow
        if (clr) begin
            cnt_next = inc_ext[STATS_WIDTH-1:0];
            ovf_next = 1'b0;
        end
        if (clr_all) begin
            cnt_next = '0;
            ovf_next = 1'b0;
        end
    end

    // Counter and flag registers
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
        end
    end

    assign cnt = cnt_reg;
    assign ovf = ovf_reg;

endmodule

// File: rtl/ip_stats_bank.sv
// ip_stats_bank: NUM_CH statistics counters with a registered read/clear port.
// Optional feature macro IP_STATS_SNAPSHOT_EN adds snapReq and a shadow bank
// that the read port returns instead of the live counters.
module ip_stats_bank
    import ip_stats_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int INC_WIDTH   = 8,
    parameter int STATS_WIDTH = 32,
    parameter int SATURATE    = STATS_WRAP,
    parameter int AW          = calc_aw(NUM_CH)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             valid,
    input  logic [NUM_CH*INC_WIDTH-1:0]   incValue,
    input  logic                          clrAll,
`ifdef IP_STATS_SNAPSHOT_EN
    input  logic                          snapReq,
`endif
    input  logic                          rdReq,
    input  logic [AW-1:0]                 rdAddr,
    input  logic                          rdClr,
    output logic                          rdValid,
    output logic [STATS_WIDTH-1:0]        rdData,
    output logic                          rdOvf,
    output logic [NUM_CH-1:0]             overflow
);

    // Read mux is padded to the full address space so unused addresses read as zero
    localparam int DEPTH = 2 ** AW;

    logic [STATS_WIDTH-1:0] cnt_arr [NUM_CH];
    logic [NUM_CH-1:0]      ovf_vec;
    logic [NUM_CH-1:0]      clr_hit;
    logic [STATS_WIDTH-1:0] src_cnt [DEPTH];
    logic [DEPTH-1:0]       src_ovf;

    logic                   rd_valid_reg;
    logic [STATS_WIDTH-1:0] rd_data_reg;
    logic                   rd_ovf_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign clr_hit[gi] = rdReq & rdClr & (rdAddr == AW'(gi));

            ip_stats_cell #(
                .INC_WIDTH  (INC_WIDTH),
                .STATS_WIDTH(STATS_WIDTH),
                .SATURATE   (SATURATE)
            ) u_cell (
                .clock    (clock),
                .reset    (reset),
                .inc_en   (valid[gi]),
                .inc_value(incValue[gi*INC_WIDTH +: INC_WIDTH]),
                .clr      (clr_hit[gi]),
                .clr_all  (clrAll),
                .cnt      (cnt_arr[gi]),
                .ovf      (ovf_vec[gi])
            );
        end
    endgenerate

`ifdef IP_STATS_SNAPSHOT_EN
    logic [STATS_WIDTH-1:0] shadow_cnt_reg [NUM_CH];
    logic [NUM_CH-1:0]      shadow_ovf_reg;

    // Shadow bank captures the registered counters, i.e. values before any same-cycle clear
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_cnt_reg[i] <= '0;
            end
            shadow_ovf_reg <= '0;
        end else if (snapReq) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_cnt_reg[i] <= cnt_arr[i];
            end
            shadow_ovf_reg <= ovf_vec;
        end
    end
`endif

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_src
            if (gi < NUM_CH) begin : g_live
`ifdef IP_STATS_SNAPSHOT_EN
                assign src_cnt[gi] = shadow_cnt_reg[gi];
                assign src_ovf[gi] = shadow_ovf_reg[gi];
`else
                assign src_cnt[gi] = cnt_arr[gi];
                assign src_ovf[gi] = ovf_vec[gi];
`endif
            end else begin : g_pad
                assign src_cnt[gi] = '0;
                assign src_ovf[gi] = 1'b0;
            end
        end
    endgenerate

    // Registered read port: samples the request-cycle values, one cycle latency
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
            rd_ovf_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= rdReq;
            if (rdReq) begin
                rd_data_reg <= src_cnt[rdAddr];
                rd_ovf_reg  <= src_ovf[rdAddr];
            end
        end
    end

    assign rdValid  = rd_valid_reg;
    assign rdData   = rd_data_reg;
    assign rdOvf    = rd_ovf_reg;
    assign overflow = ovf_vec;

endmodule

// File: tb/tb_ip_stats_bank.sv
// tb_ip_stats_bank: directed bench driving a wrapping and a saturating bank
// (NUM_CH=5, 8-bit counters) with identical stimulus; reads are scoreboarded.
module tb_ip_stats_bank;

    localparam int NCH = 5;
    localparam int IW  = 8;
    localparam int SW  = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NCH-1:0]  valid = '0;
    logic [NCH*IW-1:0] incValue = '0;
    logic            clrAll = 1'b0;
    logic            snapReq = 1'b0;
    logic            rdReq = 1'b0;
    logic [2:0]      rdAddr = '0;
    logic            rdClr = 1'b0;

    logic            rdValid_w, rdValid_s, rdOvf_w, rdOvf_s;
    logic [SW-1:0]   rdData_w, rdData_s;
    logic [NCH-1:0]  overflow_w, overflow_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit started = 1'b0;
    bit last_presnap;

    typedef struct {
        int       due;
        int       addr;
        logic [7:0] dw;
        logic     ow;
        logic [7:0] ds;
        logic     os;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    ip_stats_bank #(.NUM_CH(NCH), .INC_WIDTH(IW), .STATS_WIDTH(SW), .SATURATE(0)) dut_wrap (
        .clock(clock), .reset(reset), .valid(valid), .incValue(incValue), .clrAll(clrAll),
`ifdef IP_STATS_SNAPSHOT_EN
        .snapReq(snapReq),
`endif
        .rdReq(rdReq), .rdAddr(rdAddr), .rdClr(rdClr),
        .rdValid(rdValid_w), .rdData(rdData_w), .rdOvf(rdOvf_w), .overflow(overflow_w)
    );

    ip_stats_bank #(.NUM_CH(NCH), .INC_WIDTH(IW), .STATS_WIDTH(SW), .SATURATE(1)) dut_sat (
        .clock(clock), .reset(reset), .valid(valid), .incValue(incValue), .clrAll(clrAll),
`ifdef IP_STATS_SNAPSHOT_EN
        .snapReq(snapReq),
`endif
        .rdReq(rdReq), .rdAddr(rdAddr), .rdClr(rdClr),
        .rdValid(rdValid_s), .rdData(rdData_s), .rdOvf(rdOvf_s), .overflow(overflow_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_inc(input int ch, input int val);
        valid[ch] = 1'b1;
        incValue[ch*IW +: IW] = val[IW-1:0];
    endtask

    task automatic clear_inc();
        valid    = '0;
        incValue = '0;
    endtask

    // Issue one read; in snapshot builds an optional snapshot cycle precedes it
    task automatic issue_read(input int addr, input bit clr, input int dw, input int ow,
                              input int ds, input int os, input bit presnap);
        exp_t e;
`ifdef IP_STATS_SNAPSHOT_EN
        logic [NCH-1:0]    sv_valid;
        logic              sv_clr;
        if (presnap) begin
            sv_valid = valid;
            sv_clr   = clrAll;
            valid    = '0;
            clrAll   = 1'b0;
            snapReq  = 1'b1;
            tick();
            snapReq  = 1'b0;
            valid    = sv_valid;
            clrAll   = sv_clr;
        end
`else
        last_presnap = presnap;
`endif
        rdReq  = 1'b1;
        rdAddr = addr[2:0];
        rdClr  = clr;
        e.due  = cyc + 1;
        e.addr = addr;
        e.dw   = dw[7:0];
        e.ow   = ow[0];
        e.ds   = ds[7:0];
        e.os   = os[0];
        exp_q.push_back(e);
        tick();
        rdReq = 1'b0;
        rdClr = 1'b0;
    endtask

    // Read monitor: rdValid must assert exactly in the cycle a scoreboard entry is due
    always @(negedge clock) begin
        if (started) begin
            automatic bit want = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("rdvalid_wrap", {31'b0, rdValid_w}, {31'b0, want});
            chk("rdvalid_sat",  {31'b0, rdValid_s}, {31'b0, want});
            if (want) begin
                automatic exp_t e = exp_q.pop_front();
                $display("read ch%0d: wrap data=%0d ovf=%0b sat data=%0d ovf=%0b",
                         e.addr, rdData_w, rdOvf_w, rdData_s, rdOvf_s);
                chk("rddata_wrap", {24'b0, rdData_w}, {24'b0, e.dw});
                chk("rdovf_wrap",  {31'b0, rdOvf_w},  {31'b0, e.ow});
                chk("rddata_sat",  {24'b0, rdData_s}, {24'b0, e.ds});
                chk("rdovf_sat",   {31'b0, rdOvf_s},  {31'b0, e.os});
            end
        end
    end

    initial begin
        // Reset
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_rdvalid", {31'b0, rdValid_w}, 0);
        chk("rst_rddata",  {24'b0, rdData_w}, 0);
        chk("rst_rdovf",   {31'b0, rdOvf_s}, 0);
        chk("rst_ovf_wrap", {27'b0, overflow_w}, 0);
        chk("rst_ovf_sat",  {27'b0, overflow_s}, 0);
        started = 1'b1;

        // ch0: three increments of 5
        set_inc(0, 5);
        repeat (3) tick();
        clear_inc();
        issue_read(0, 0, 15, 0, 15, 0, 1);
        tick();

        // ch1: 250 then +10 overflows
        set_inc(1, 250); tick();
        clear_inc(); set_inc(1, 10); tick();
        clear_inc();
        chk("ovf1_wrap", {27'b0, overflow_w}, 32'h02);
        chk("ovf1_sat",  {27'b0, overflow_s}, 32'h02);
        // read returns pre-update value while +1 lands
        set_inc(1, 1);
        issue_read(1, 0, 4, 1, 255, 1, 1);
        clear_inc();
        // back-to-back reads, flag still sticky
        issue_read(1, 0, 5, 1, 255, 1, 1);
        issue_read(0, 0, 15, 0, 15, 0, 1);

        // clearing read of ch1 with coincident +3
        set_inc(1, 3);
        issue_read(1, 1, 5, 1, 255, 1, 1);
        clear_inc();
        chk("ovf_clr_wrap", {27'b0, overflow_w}, 0);
        chk("ovf_clr_sat",  {27'b0, overflow_s}, 0);
        issue_read(1, 0, 3, 0, 3, 0, 1);

        // ch2: 100, clearing read with coincident +7
        set_inc(2, 100); tick();
        clear_inc(); set_inc(2, 7);
        issue_read(2, 1, 100, 0, 100, 0, 1);
        clear_inc();
        issue_read(2, 0, 7, 0, 7, 0, 1);

        // ch3 = 40, ch4 overflows, then clrAll with increments everywhere and rdClr
        set_inc(3, 40); tick();
        clear_inc(); set_inc(4, 200); tick(); tick();
        clear_inc();
        chk("ovf4_wrap", {27'b0, overflow_w}, 32'h10);
        chk("ovf4_sat",  {27'b0, overflow_s}, 32'h10);
        for (int c = 0; c < NCH; c++) set_inc(c, 9);
        clrAll = 1'b1;
        issue_read(3, 1, 40, 0, 40, 0, 1);
        clrAll = 1'b0;
        clear_inc();
        chk("clrall_ovf_wrap", {27'b0, overflow_w}, 0);
        chk("clrall_ovf_sat",  {27'b0, overflow_s}, 0);
        for (int c = 0; c < NCH; c++) issue_read(c, 0, 0, 0, 0, 0, 1);
        issue_read(NCH, 0, 0, 0, 0, 0, 1);
        issue_read(7, 1, 0, 0, 0, 0, 1);

        // reset during a read request: no read response, counters cleared
        set_inc(0, 5); tick();
        clear_inc();
        rdReq = 1'b1; rdAddr = 3'd0; reset = 1'b1;
        tick();
        reset = 1'b0; rdReq = 1'b0;
        chk("midrst_rdvalid", {31'b0, rdValid_w}, 0);
        issue_read(0, 0, 0, 0, 0, 0, 1);

`ifdef IP_STATS_SNAPSHOT_EN
        // snapshot holds 20 while live counter moves on to 25
        set_inc(0, 20); tick();
        clear_inc();
        snapReq = 1'b1; tick(); snapReq = 1'b0;
        set_inc(0, 1); repeat (5) tick();
        clear_inc();
        issue_read(0, 0, 20, 0, 20, 0, 0);
        issue_read(0, 0, 25, 0, 25, 0, 1);
`endif

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
